uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_if.sv | 18 +
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default baud constants
// Purpose: receiver FSM state enum, default frame/baud constants and a
//          majority-vote helper, shared by the receiver and the transmitter.
// Ports:   none (package).
package uart_pkg;

  // 100 MHz clock at 115200 baud, 8 data bits
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DEFAULT_DATA_WIDTH   = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver line and received-frame bundle
// Purpose: groups the serial line and the received-frame outputs.
// Ports:   serial_in (line, idle high), received_data (last good frame),
//          data_is_valid (1-cycle pulse), rx_error (1-cycle pulse).
//          master = line driver / frame consumer, slave = receiver.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = UART_DEFAULT_DATA_WIDTH
);
  logic                        serial_in;
  logic [INPUT_DATA_WIDTH-1:0] received_data;
  logic                        data_is_valid;
  logic                        rx_error;

  modport master (output serial_in, input received_data, input data_is_valid, input rx_error);
  modport slave  (input serial_in, output received_data, output data_is_valid, output rx_error);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - serial line synchronizer and falling-edge detect
// Purpose: two-flop synchronizer for the asynchronous line plus one history
//          flop for falling-edge detection.
// Ports:   clk, reset_rx_n (sync, active low), i_serial (async line),
//          o_s (synchronized line), o_fall (previous 1, current 0).
module uart_rx_sync (
  input  logic clk,
  input  logic reset_rx_n,
  input  logic i_serial,
  output logic o_s,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All three flops clear to 0, so a line held low through reset release
  // cannot look like a falling edge until it has been seen high first.
  always_ff @(posedge clk) begin
    if (!reset_rx_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_serial;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_s    = r_sync;
  assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with 3-sample majority vote
// Purpose: receives start/data/optional even parity/stop frames, LSB first.
// Ports:   clk, reset_rx_n (sync, active low),
//          rx_if.slave: serial_in, received_data, data_is_valid, rx_error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = UART_DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT     = UART_DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN        = 0
) (
  input  logic     clk,
  input  logic     reset_rx_n,
  uart_rx_if.slave rx_if
);
  localparam int                BIT_W       = $clog2(INPUT_DATA_WIDTH + 1);
  localparam logic [15:0]       LP_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]       LP_HALF     = 16'(CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0]  LP_LAST_BIT = BIT_W'(INPUT_DATA_WIDTH - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_cpb
      $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
  endgenerate

  logic                        w_s;
  logic                        w_fall;
  logic                        w_tick;
  logic                        w_vote;
  logic                        w_load;
  logic                        w_err;
  logic [INPUT_DATA_WIDTH:0]   w_shift_in;
  rx_state_t                   r_state;
  rx_state_t                   w_next;
  logic [15:0]                 r_cnt;
  logic [BIT_W-1:0]            r_bit;
  logic [INPUT_DATA_WIDTH-1:0] r_shift;
  logic [INPUT_DATA_WIDTH-1:0] r_data;
  logic                        r_v_lo;
  logic                        r_v_mid;
  logic                        r_par_err;
  logic                        r_valid;
  logic                        r_err;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset_rx_n (reset_rx_n),
    .i_serial   (rx_if.serial_in),
    .o_s        (w_s),
    .o_fall     (w_fall)
  );

  // Decision point of every bit: the third vote sample is the live s.
  assign w_tick     = (r_cnt == LP_HALF + 16'd1);
  assign w_vote     = majority3(r_v_lo, r_v_mid, w_s);
  assign w_shift_in = {w_vote, r_shift};

  always_ff @(posedge clk) begin
    if (!reset_rx_n) r_state <= RX_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_IDLE:      if (w_fall) w_next = RX_START;
      RX_START:     if (w_tick) w_next = w_vote ? RX_IDLE : RX_DATA;
      RX_DATA:      if (w_tick && (r_bit == LP_LAST_BIT))
                      w_next = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (w_tick) w_next = RX_STOP;
      // Leaving at mid-stop gives half a bit of slack for the next start edge.
      RX_STOP:      if (w_tick) w_next = w_vote ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (w_s) w_next = RX_IDLE;
      default:      w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_err  = 1'b0;
    if ((r_state == RX_STOP) && w_tick) begin
      w_load = w_vote & ~r_par_err;
      w_err  = ~w_vote | r_par_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_rx_n) begin
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_v_lo    <= 1'b0;
      r_v_mid   <= 1'b0;
      r_par_err <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= w_load;
      r_err   <= w_err;
      if (w_load) r_data <= r_shift;
      if (r_state == RX_IDLE) begin
        // Counter held at 0 so a start edge begins the frame at count 0.
        r_cnt     <= '0;
        r_bit     <= '0;
        r_par_err <= 1'b0;
      end else begin
        r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 16'd1;
        if (r_cnt == LP_HALF - 16'd1) r_v_lo  <= w_s;
        if (r_cnt == LP_HALF)         r_v_mid <= w_s;
        if (w_tick && (r_state == RX_DATA)) begin
          r_shift <= w_shift_in[INPUT_DATA_WIDTH:1];
          r_bit   <= r_bit + BIT_W'(1);
        end
        if (w_tick && (r_state == RX_PARITY)) r_par_err <= (^r_shift) ^ w_vote;
      end
    end
  end

  assign rx_if.received_data = r_data;
  assign rx_if.data_is_valid = r_valid;
  assign rx_if.rx_error      = r_err;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (no parity and even parity)
module tb_uart_rx;
  localparam int CPB = 16;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset_rx_n;
  logic       line [2];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good [2];
  exp_t       q0 [$];
  exp_t       q1 [$];

  uart_rx_if #(.INPUT_DATA_WIDTH(8)) if0 ();
  uart_rx_if #(.INPUT_DATA_WIDTH(8)) if1 ();

  assign if0.serial_in = line[0];
  assign if1.serial_in = line[1];

  uart_rx #(.INPUT_DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset_rx_n(reset_rx_n), .rx_if(if0));
  uart_rx #(.INPUT_DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset_rx_n(reset_rx_n), .rx_if(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input int i, input logic v, input int n);
    line[i] = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference: the frame's outcome and the cycle its pulse must appear,
  // counted from the first rising edge that samples the start bit.
  task automatic send_frame(input int i, input logic [7:0] data, input bit has_par,
                            input logic par_bit, input logic stop_bit);
    exp_t x;
    x.is_err = (stop_bit == 1'b0) || (has_par && (par_bit != ^data));
    x.data   = data;
    x.cyc    = cyc + 1 + (9 + (has_par ? 1 : 0)) * CPB + CPB / 2 + 4;
    if (i == 0) q0.push_back(x);
    else        q1.push_back(x);
    drive(i, 1'b0, CPB);
    for (int b = 0; b < 8; b++) drive(i, data[b], CPB);
    if (has_par) drive(i, par_bit, CPB);
    drive(i, stop_bit, CPB);
  endtask

  task automatic mon(input int i, input logic v, input logic e, input logic [7:0] d);
    exp_t x;
    if ((v === 1'b1) || (e === 1'b1)) begin
      check($sformatf("dut%0d_valid_and_error", i), 32'(v & e), 32'd0);
      if (((i == 0) ? q0.size() : q1.size()) == 0) begin
        check($sformatf("dut%0d_unexpected_pulse", i), 32'({v, e}), 32'd0);
      end else begin
        x = (i == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d_pulse_kind", i), 32'({v, e}), x.is_err ? 32'd1 : 32'd2);
        check($sformatf("dut%0d_pulse_cycle", i), cyc, x.cyc);
        if (x.is_err) begin
          check($sformatf("dut%0d_data_kept", i), 32'(d), 32'(last_good[i]));
        end else begin
          check($sformatf("dut%0d_data_value", i), 32'(d), 32'(x.data));
          last_good[i] = x.data;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, if0.data_is_valid, if0.rx_error, if0.received_data);
      mon(1, if1.data_is_valid, if1.rx_error, if1.received_data);
    end
  end

  initial begin
    logic [7:0] f;
    logic [7:0] rd;
    int         gap;
    bit         ferr;
    bit         perr;

    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    line[0]      = 1'b1;
    line[1]      = 1'b1;
    reset_rx_n   = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_data0",  32'(if0.received_data), 32'd0);
    check("reset_valid0", 32'(if0.data_is_valid), 32'd0);
    check("reset_err0",   32'(if0.rx_error), 32'd0);
    check("reset_data1",  32'(if1.received_data), 32'd0);
    reset_rx_n = 1'b1;
    drive(0, 1'b1, 2 * CPB);

    // Single frame, then three back-to-back frames.
    send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, CPB);
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, CPB);

    // Short glitch is rejected as a false start.
    drive(0, 1'b0, 6);
    drive(0, 1'b1, 3 * CPB);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, CPB);

    // Framing error followed by a held-low line.
    send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 40);
    drive(0, 1'b1, 2 * CPB);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, CPB);

    // Even parity good then bad.
    drive(1, 1'b1, CPB);
    send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1);
    drive(1, 1'b1, CPB);
    send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1);
    drive(1, 1'b1, CPB);

    // Reset in the middle of data bit 4 (a 0 bit), line low across release.
    f = 8'hA3;
    drive(0, 1'b0, CPB);
    for (int b = 0; b < 4; b++) drive(0, f[b], CPB);
    drive(0, f[4], CPB / 2);
    reset_rx_n = 1'b0;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (4) @(negedge clk);
    reset_rx_n = 1'b1;
    drive(0, 1'b0, 3 * CPB);
    check("post_reset_data0",  32'(if0.received_data), 32'd0);
    check("post_reset_valid0", 32'(if0.data_is_valid), 32'd0);
    check("post_reset_err0",   32'(if0.rx_error), 32'd0);
    drive(0, 1'b1, 2 * CPB);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, CPB);

    // Randomized frames on both receivers.
    for (int k = 0; k < 20; k++) begin
      rd   = 8'($urandom_range(0, 255));
      ferr = ($urandom_range(0, 7) == 0);
      send_frame(0, rd, 1'b0, 1'b0, ~ferr);
      if (ferr) begin
        drive(0, 1'b0, $urandom_range(0, 30));
        gap = $urandom_range(3, 20);
      end else begin
        gap = $urandom_range(0, 20);
      end
      if (gap > 0) drive(0, 1'b1, gap);
    end
    drive(0, 1'b1, CPB);
    for (int k = 0; k < 20; k++) begin
      rd   = 8'($urandom_range(0, 255));
      perr = ($urandom_range(0, 3) == 0);
      send_frame(1, rd, 1'b1, (^rd) ^ perr, 1'b1);
      gap = $urandom_range(0, 20);
      if (gap > 0) drive(1, 1'b1, gap);
    end

    drive(1, 1'b1, 4 * CPB);
    check("pending_dut0", q0.size(), 32'd0);
    check("pending_dut1", q1.size(), 32'd0);
    check("final_data0", 32'(if0.received_data), 32'(last_good[0]));
    check("final_data1", 32'(if1.received_data), 32'(last_good[1]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
